// File: rtl/dac_sched_pkg.sv
// ----------------------------------------------------------------------------
// dac_sched_pkg
// Shared definitions for the DAC mixing scheduler:
//   - state_e    : scheduler FSM states (IDLE, ACCUM, SAT, OUT)
//   - SMP_W      : width of one requester sample (signed two's complement)
//   - MIDSCALE   : excess-128 code for a zero output level
//   - acc_width(): accumulator width wide enough to sum NREQ samples plus sign
// ----------------------------------------------------------------------------
package dac_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SAT   = 2'd2,
        OUT   = 2'd3
    } state_e;

    localparam int         SMP_W    = 8;
    localparam logic [7:0] MIDSCALE = 8'h80;

    // Summing n signed SMP_W-bit values needs clog2(n) growth bits; one extra
    // bit of headroom keeps the sign unambiguous for the clamp stage.
    function automatic int acc_width(input int nreq);
        return SMP_W + $clog2(nreq) + 1;
    endfunction

endpackage

// File: rtl/dac_rate_div.sv
// ----------------------------------------------------------------------------
// dac_rate_div
// Sample-rate divider: counts 0..DIV-1 and asserts tick_o while the count is
// DIV-1. The counter is forced to 0 whenever en_i is low.
//   clk_i  in  system clock
//   rst_i  in  asynchronous active-high reset
//   en_i   in  count enable
//   tick_o out high during the last cycle of each DIV-cycle period
// ----------------------------------------------------------------------------
module dac_rate_div #(
    parameter int DIV = 256
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] count_q, count_d;
    logic             en_q;

    // The cycle in which en_i first rises is spent with the count still at 0,
    // so the first tick after enabling lands DIV cycles later and the first
    // output strobe DIV+7 cycles after the enable edge.
    always_comb begin
        if (!(en_i && en_q)) begin
            count_d = '0;
        end else if (count_q == CNT_W'(DIV - 1)) begin
            count_d = '0;
        end else begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
            en_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            en_q    <= en_i;
        end
    end

    assign tick_o = (count_q == CNT_W'(DIV - 1));

endmodule

// File: rtl/dac_mix_sched.sv
// ----------------------------------------------------------------------------
// dac_mix_sched
// Shares one 8-bit delta-sigma DAC between NREQ sample sources. On each
// sample tick the FSM visits every requester once (ACCUM), collecting a fresh
// sample over valid/ready or reusing the last held one on underrun, clamps the
// sum to 8 bits (SAT) and loads the excess-128 code into the DAC (OUT).
//
// Optional feature macro: DAC_SOFT_MUTE_EN adds mute_i; while it is high each
// frame steps dac_code_o one LSB toward midscale instead of loading the mix.
//
// Ports:
//   clk_i        in   system clock
//   rst_i        in   asynchronous active-high reset
//   en_i         in   scheduler enable (only sampled in IDLE)
//   smp_i        in   NREQ packed signed samples, lane i = [8i+7:8i]
//   smp_valid_i  in   per-requester sample valid
//   smp_ready_o  out  per-requester take pulse
//   dac_code_o   out  excess-128 DAC code, held between frames
//   strobe_o     out  one-cycle pulse when dac_code_o updates
//   underrun_o   out  sticky per-requester underrun flags
//   clr_i        in   clears underrun_o (a coincident new underrun wins)
//   mute_i       in   soft-mute request (DAC_SOFT_MUTE_EN only)
//   busy_o       out  FSM not in IDLE
// ----------------------------------------------------------------------------
module dac_mix_sched
    import dac_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DIV  = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic [SMP_W*NREQ-1:0] smp_i,
    input  logic [NREQ-1:0]       smp_valid_i,
    output logic [NREQ-1:0]       smp_ready_o,
    output logic [7:0]            dac_code_o,
    output logic                  strobe_o,
    output logic [NREQ-1:0]       underrun_o,
    input  logic                  clr_i,
`ifdef DAC_SOFT_MUTE_EN
    input  logic                  mute_i,
`endif
    output logic                  busy_o
);

    localparam int ACC_W = acc_width(NREQ);
    localparam int IDX_W = $clog2(NREQ);

    state_e               state_q;
    logic [IDX_W-1:0]     idx_q;
    logic [ACC_W-1:0]     acc_q;
    logic [SMP_W-1:0]     sat_q;
    logic [7:0]           dac_q;
    logic                 strobe_q;
    logic [NREQ-1:0]      underrun_q, underrun_d;
    logic [NREQ-1:0]      ur_set;
    logic [SMP_W-1:0]     hold_q [NREQ];
    logic [SMP_W-1:0]     lane   [NREQ];
    logic                 tick;
    logic [SMP_W-1:0]     cur_smp;
    logic [ACC_W-1:0]     cur_ext;
    logic [SMP_W-1:0]     clamp_d;
    logic [ACC_W-SMP_W:0] acc_top;

    dac_rate_div #(
        .DIV (DIV)
    ) u_rate_div (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (en_i),
        .tick_o (tick)
    );

    // Per-lane unpacking, ready pulses and underrun events. Ready is decoded
    // straight from the state register so the handshake completes in the
    // requester's own ACCUM cycle.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
        assign lane[gi]        = smp_i[SMP_W*gi +: SMP_W];
        assign smp_ready_o[gi] = (state_q == ACCUM) && (idx_q == IDX_W'(gi)) &&  smp_valid_i[gi];
        assign ur_set[gi]      = (state_q == ACCUM) && (idx_q == IDX_W'(gi)) && !smp_valid_i[gi];
    end

    // Fresh sample when valid, otherwise repeat the last one taken.
    assign cur_smp = smp_valid_i[idx_q] ? lane[idx_q] : hold_q[idx_q];
    assign cur_ext = {{(ACC_W-SMP_W){cur_smp[SMP_W-1]}}, cur_smp};

    // acc fits in 8 signed bits only when bits [ACC_W-1:7] are all equal.
    assign acc_top = acc_q[ACC_W-1:SMP_W-1];
    always_comb begin
        clamp_d = acc_q[SMP_W-1:0];
        if (!((&acc_top) || !(|acc_top))) begin
            clamp_d = acc_q[ACC_W-1] ? 8'h80 : 8'h7F;
        end
    end

    // Set has priority over clear so no underrun event is lost.
    assign underrun_d = (clr_i ? '0 : underrun_q) | ur_set;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            underrun_q <= '0;
            for (int i = 0; i < NREQ; i++) begin
                hold_q[i] <= '0;
            end
        end else begin
            underrun_q <= underrun_d;
            for (int i = 0; i < NREQ; i++) begin
                if (smp_ready_o[i]) begin
                    hold_q[i] <= lane[i];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            acc_q    <= '0;
            sat_q    <= '0;
            dac_q    <= MIDSCALE;
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (tick && en_i) begin
                        state_q <= ACCUM;
                        idx_q   <= '0;
                        acc_q   <= '0;
                    end
                end
                ACCUM: begin
                    acc_q <= acc_q + cur_ext;
                    if (idx_q == IDX_W'(NREQ - 1)) begin
                        state_q <= SAT;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                SAT: begin
                    sat_q   <= clamp_d;
                    state_q <= OUT;
                end
                OUT: begin
`ifdef DAC_SOFT_MUTE_EN
                    if (mute_i) begin
                        if (dac_q > MIDSCALE) begin
                            dac_q <= dac_q - 8'd1;
                        end else if (dac_q < MIDSCALE) begin
                            dac_q <= dac_q + 8'd1;
                        end
                    end else begin
                        dac_q <= sat_q ^ MIDSCALE;
                    end
`else
                    // Inverting the MSB turns signed two's complement into
                    // excess-128.
                    dac_q <= sat_q ^ MIDSCALE;
`endif
                    strobe_q <= 1'b1;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dac_code_o = dac_q;
    assign strobe_o   = strobe_q;
    assign underrun_o = underrun_q;
    assign busy_o     = (state_q != IDLE);

endmodule
